vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing source for the 640x480@60 Hz VGA path. It divides the system clock into a pixel tick and runs the horizontal/vertical counters. It generates sync and visible-area flags and issues frame/second ticks. It also snapshots the Sudoku board once per frame so the downstream game pixel generator reads a stable board for the whole visible area. It sits directly upstream of the game pixel generator, which consumes `h_cnt`, `v_cnt`, `board_out` and `blank_out`.

## Interface
- `DIV`, 4: system clocks per pixel; minimum 2.
- `FPS`, 60: frames per `sec_tick`.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `board_in` in 324: 81 cells × 4 bits; cell k at [4k+3:4k]; value 0 = empty.
- `blank_in` in 81: per-cell flag; 1 = player-entered cell.
- `h_cnt` out 10: horizontal position, 0..799.
- `v_cnt` out 10: vertical position, 0..524.
- `hsync` out 1: active low.
- `vsync` out 1: active low.
- `valid` out 1: high when `h_cnt`<640 and `v_cnt`<480.
- `pix_tick` out 1: one-clk pulse in the last clk of each pixel.
- `frame_tick` out 1: one-clk pulse at the start of vertical blanking.
- `sec_tick` out 1: one-clk pulse once every `FPS` frames.
- `board_out` out 324: frame-stable copy of `board_in`.
- `blank_out` out 81: frame-stable copy of `blank_in`.

## Operation
- Divider `div` counts 0..DIV-1 and wraps. `pix_tick` = (`div`==DIV-1), combinational from the register.
- On each clk edge where `pix_tick` is high, `h_cnt` increments.
  - At 799, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At (799,524), both counters wrap to 0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- `hsync`=0 iff 656≤`h_cnt`≤751. `vsync`=0 iff 490≤`v_cnt`≤491.
  - Both are registered from the next-count decode, so they align with the counters in the same cycle; no extra skew.
- `valid` is combinational from the counter registers.
- `frame_tick` is registered. It is high for exactly the first clk in which (`h_cnt`,`v_cnt`)=(0,480).
- Snapshot: `board_out`/`blank_out` load `board_in`/`blank_in` on the same edge that raises `frame_tick`.
  - They hold through the next 525 lines. They never change while `valid` is high.
- Frame counter `fcnt` (0..FPS-1) increments on every `frame_tick` edge.
  - `sec_tick` pulses in the same cycle as the `frame_tick` whose load wraps `fcnt` from FPS-1 to 0.
  - The first `sec_tick` after reset is coincident with the FPS-th `frame_tick`.
- Reset (async, any time, including mid-line or mid-snapshot), all registers clear immediately:
  - `div`, `h_cnt`, `v_cnt`, `fcnt` = 0.
  - `hsync`=`vsync`=1; `valid`=1 (decoded from 0,0); `pix_tick`=0.
  - `frame_tick`=`sec_tick`=0; `board_out`=0; `blank_out`=0.
  - Counting restarts from (0,0) on release.
- Changes on `board_in` at any time other than the snapshot edge have no effect on the outputs.

## Timing
- Each (h,v) position is held for exactly DIV clks. A line is 800·DIV clks; a frame is 420000·DIV clks (1 680 000 at DIV=4).
- After reset release, the first counter advance happens on the DIV-th rising edge.
- `frame_tick` first asserts 480·800·DIV clks after release (1 536 000 at DIV=4).
- All outputs are registered or decoded from registers only; there are no input-to-output combinational paths.

## Structure
- Shared package `vga_pkg` holds:
  - H_VIS=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOT=800.
  - V_VIS=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOT=525.
  - CELLS=81, CELL_W=4.
- One sub-module, `pixel_clk_div` (parameter DIV; ports clk, rst, `pix_tick`), instantiated once.
- The counters, sync decode, snapshot and frame counter live in the top module.

## Test plan
- **Reset then run, DIV=4:**
  - Before release, outputs match the reset values listed under Operation.
  - `h_cnt` goes 0→1 on the 4th edge after release.
  - `pix_tick` is high every 4th clk.
- **Line wrap:**
  - `h_cnt` goes 799→0 with `v_cnt` +1.
  - `hsync` is low for exactly 96·4 clks, starting when `h_cnt`=656.
  - `valid` drops at `h_cnt`=640.
- **Frame wrap:**
  - (799,524)→(0,0).
  - `vsync` is low for exactly 2 lines starting at `v_cnt`=490.
  - Frame length is 1 680 000 clks.
- **Snapshot:**
  - Drive `board_in` cell 40 = 4'h7, `blank_in`[40]=1 mid-frame.
  - `board_out` stays at its old value until the edge raising `frame_tick`, then reads 7 / 1.
  - Toggling `board_in` while `valid`=1 never changes `board_out`.
- **sec_tick:**
  - With FPS=3, `sec_tick` coincides with the 3rd and 6th `frame_tick` only.
- **Async reset mid-line at (300,100):**
  - All outputs return to reset values without waiting for a clk edge.
  - After release, the counters resume from (0,0) and `board_out`=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and board geometry for the VGA path.
package vga_pkg;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned H_TOT  = 800;

    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam int unsigned V_TOT  = 525;

    localparam int unsigned CELLS   = 81;
    localparam int unsigned CELL_W  = 4;
    localparam int unsigned BOARD_W = CELLS * CELL_W;
    localparam int unsigned CNT_W   = 10;

    function automatic logic in_range(input logic [CNT_W-1:0] cnt,
                                      input int unsigned lo,
                                      input int unsigned hi);
        int unsigned c;
        c = 32'(cnt);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/pixel_clk_div.sv
// Divides the system clock into a one-clock pixel tick every DIV clocks.
module pixel_clk_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int unsigned DW = $clog2(DIV);

    logic [DW-1:0] div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (div == DW'(DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign pix_tick = (div == DW'(DIV - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: h/v counters, syncs, visible flag, frame/second
// ticks and a once-per-frame snapshot of the Sudoku board.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned DIV = 4,
    parameter int unsigned FPS = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BOARD_W-1:0]   board_in,
    input  logic [CELLS-1:0]     blank_in,
    output logic [CNT_W-1:0]     h_cnt,
    output logic [CNT_W-1:0]     v_cnt,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 valid,
    output logic                 pix_tick,
    output logic                 frame_tick,
    output logic                 sec_tick,
    output logic [BOARD_W-1:0]   board_out,
    output logic [CELLS-1:0]     blank_out
);

    localparam int unsigned FW = (FPS > 1) ? $clog2(FPS) : 1;

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             frame_start;
    logic [FW-1:0]    fcnt;

    pixel_clk_div #(.DIV(DIV)) u_div (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick)
    );

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (pix_tick) begin
            if (h_cnt == CNT_W'(H_TOT - 1)) begin
                h_next = '0;
                if (v_cnt == CNT_W'(V_TOT - 1)) begin
                    v_next = '0;
                end else begin
                    v_next = v_cnt + CNT_W'(1);
                end
            end else begin
                h_next = h_cnt + CNT_W'(1);
            end
        end
    end

    // Qualified by pix_tick so only the advancing edge into (0,V_VIS) fires.
    assign frame_start = pix_tick && (h_next == '0) && (v_next == CNT_W'(V_VIS));

    // Syncs decode the next count so they line up with the counters they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            hsync <= !in_range(h_next, H_VIS + H_FP, H_VIS + H_FP + H_SYNC - 1);
            vsync <= !in_range(v_next, V_VIS + V_FP, V_VIS + V_FP + V_SYNC - 1);
        end
    end

    assign valid = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
            sec_tick   <= 1'b0;
            fcnt       <= '0;
            board_out  <= '0;
            blank_out  <= '0;
        end else begin
            frame_tick <= frame_start;
            sec_tick   <= frame_start && (fcnt == FW'(FPS - 1));
            if (frame_start) begin
                board_out <= board_in;
                blank_out <= blank_in;
                if (fcnt == FW'(FPS - 1)) begin
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a pixel-index reference model queues
// the expected outputs each clock and a negedge monitor compares them.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int unsigned DIV = 4;
    localparam int unsigned FPS = 3;
    localparam int unsigned FRAME_PIX = 800 * 525;

    logic         clk = 1'b0;
    logic         rst;
    logic [323:0] board_in;
    logic [80:0]  blank_in;
    logic [9:0]   h_cnt, v_cnt;
    logic         hsync, vsync, valid, pix_tick, frame_tick, sec_tick;
    logic [323:0] board_out;
    logic [80:0]  blank_out;

    vga_timing_gen #(.DIV(DIV), .FPS(FPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .board_in   (board_in),
        .blank_in   (blank_in),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .hsync      (hsync),
        .vsync      (vsync),
        .valid      (valid),
        .pix_tick   (pix_tick),
        .frame_tick (frame_tick),
        .sec_tick   (sec_tick),
        .board_out  (board_out),
        .blank_out  (blank_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  h;
        int unsigned  v;
        bit           hs, vs, vld, pt, ft, st;
        logic [323:0] board;
        logic [80:0]  blank;
    } exp_t;

    exp_t        sb[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: position is a linear pixel index within the frame.
    bit           m_rst;
    int unsigned  m_k;
    int unsigned  m_p;
    int unsigned  m_frames;
    bit           m_ft, m_st;
    logic [323:0] m_board;
    logic [80:0]  m_blank;
    bit           churn;
    logic [9:0]   frc_h, frc_v;

    function automatic logic [323:0] rand_board();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
        return t[323:0];
    endfunction

    function automatic logic [80:0] rand_blank();
        logic [95:0] t;
        for (int i = 0; i < 3; i++) t[i*32 +: 32] = $urandom;
        return t[80:0];
    endfunction

    task automatic model_clear();
        m_k = 0; m_p = 0; m_frames = 0; m_ft = 0; m_st = 0;
        m_board = '0; m_blank = '0;
    endtask

    task automatic advance();
        m_ft = 0;
        m_st = 0;
        if (!m_rst) begin
            m_k++;
            if (m_k % DIV == 0) begin
                m_p = (m_p + 1) % FRAME_PIX;
                if (m_p == 480 * 800) begin
                    m_ft = 1;
                    m_frames++;
                    m_st = (m_frames % FPS == 0);
                    m_board = board_in;
                    m_blank = blank_in;
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.h     = m_p % 800;
        e.v     = (m_p / 800) % 525;
        e.pt    = !m_rst && (m_k % DIV == DIV - 1);
        e.hs    = !(e.h >= 656 && e.h <= 751);
        e.vs    = !(e.v >= 490 && e.v <= 491);
        e.vld   = (e.h < 640) && (e.v < 480);
        e.ft    = m_ft;
        e.st    = m_st;
        e.board = m_board;
        e.blank = m_blank;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        advance();
        push_exp();
        if (churn && $urandom_range(0, 3) == 0) begin
            board_in = rand_board();
            blank_in = rand_blank();
        end
    endtask

    task automatic run_pix(input int unsigned n);
        repeat (n * DIV) cyc();
    endtask

    // Presets the counters so the next advancing edge lands on (0,v_target).
    // The force spans that edge, so the register and the released value agree.
    task automatic jump(input int unsigned v_target);
        while (((m_k + 1) % DIV) != 0) cyc();
        @(negedge clk); #1;
        frc_h = 10'(799);
        frc_v = 10'(v_target - 1);
        force dut.h_cnt = frc_h;
        force dut.v_cnt = frc_v;
        @(posedge clk); #1;
        frc_h = '0;
        frc_v = 10'(v_target);
        force dut.h_cnt = frc_h;
        force dut.v_cnt = frc_v;
        release dut.h_cnt;
        release dut.v_cnt;
        m_p = v_target * 800 - 1;
        advance();
        push_exp();
    endtask

    task automatic assert_rst();
        @(posedge clk); #1;
        advance();
        rst = 1'b1;
        m_rst = 1;
        model_clear();
        push_exp();
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        advance();
        rst = 1'b0;
        m_rst = 0;
        m_k = 0;
        push_exp();
    endtask

    always @(negedge clk) begin
        exp_t         e;
        string        name;
        logic [323:0] act, want;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            name = "";
            act = '0;
            want = '0;
            if (32'(h_cnt) != e.h) begin
                name = "h_cnt"; act = 324'(h_cnt); want = 324'(e.h);
            end else if (32'(v_cnt) != e.v) begin
                name = "v_cnt"; act = 324'(v_cnt); want = 324'(e.v);
            end else if (hsync !== e.hs) begin
                name = "hsync"; act = 324'(hsync); want = 324'(e.hs);
            end else if (vsync !== e.vs) begin
                name = "vsync"; act = 324'(vsync); want = 324'(e.vs);
            end else if (valid !== e.vld) begin
                name = "valid"; act = 324'(valid); want = 324'(e.vld);
            end else if (pix_tick !== e.pt) begin
                name = "pix_tick"; act = 324'(pix_tick); want = 324'(e.pt);
            end else if (frame_tick !== e.ft) begin
                name = "frame_tick"; act = 324'(frame_tick); want = 324'(e.ft);
            end else if (sec_tick !== e.st) begin
                name = "sec_tick"; act = 324'(sec_tick); want = 324'(e.st);
            end else if (board_out !== e.board) begin
                name = "board_out"; act = board_out; want = e.board;
            end else if (blank_out !== e.blank) begin
                name = "blank_out"; act = 324'(blank_out); want = 324'(e.blank);
            end
            if (name != "") begin
                miscompares++;
                $display("FAIL %s at exp (%0d,%0d) t=%0t: got %0h want %0h",
                         name, e.h, e.v, $time, act, want);
            end
        end
    end

    initial begin
        rst = 1'b1;
        m_rst = 1;
        model_clear();
        churn = 1;
        board_in = rand_board();
        blank_in = rand_blank();
        repeat (4) cyc();
        release_rst();

        // First line and the wrap into line 1.
        run_pix(810);

        // Natural line wrap into v=480 with a known cell 40 pattern.
        jump(479);
        run_pix(100);
        churn = 0;
        board_in[160 +: 4] = 4'h7;
        blank_in[40] = 1'b1;
        run_pix(705);
        churn = 1;
        run_pix(30);

        // Vertical sync window.
        jump(489);
        run_pix(1610);

        // Frame wrap from the last line.
        jump(524);
        run_pix(805);

        // More frames for the sec_tick cadence.
        for (int f = 0; f < 5; f++) begin
            jump(480);
            run_pix(8);
        end
        jump(524);
        run_pix(805);

        // Asynchronous reset in the middle of a line.
        jump(100);
        run_pix(300);
        repeat (2) cyc();
        assert_rst();
        repeat (3) cyc();
        release_rst();
        run_pix(50);

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
